// File: rtl/spi_flash_resp.sv
// SPI flash command responder: WREN, RDSR, SE with busy timer, optional RDID.
// Define SPI_FLASH_RESP_RDID_EN to answer 8'h9F with JEDEC_ID.
`timescale 1ns/1ps
module spi_flash_resp #(
    parameter logic [31:0] BUSY_CYC = 32'd2_500_000,
    parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cs_n,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        se_done,
    output logic [23:0] se_addr,
    output logic        wip,
    output logic        wel
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        STAT,
        ID,
        IGNORE
    } state_t;

    state_t      state_q;
    logic        cs_m_q, cs_s_q, cs_p_q;
    logic        sck_m_q, sck_s_q, sck_p_q;
    logic        mosi_m_q, mosi_s_q;
    logic [6:0]  sr_q;
    logic [5:0]  bcnt_q;
    logic [2:0]  ph_q;
    logic [1:0]  idx_q;
    logic        wren_q;
    logic [23:0] addr_q;
    logic [7:0]  tx_q;
    logic        miso_q;
    logic        wip_q;
    logic        wel_q;
    logic        se_done_q;
    logic [23:0] se_addr_q;
    logic [31:0] busy_q;

    logic        cs_fall, cs_rise, sck_rise, sck_fall;
    logic [7:0]  cmd_byte;
    logic [7:0]  stat_byte;
    logic [7:0]  id_byte;
    logic [5:0]  bcnt_d;

    assign cs_fall   = cs_p_q & ~cs_s_q;
    assign cs_rise   = ~cs_p_q & cs_s_q;
    assign sck_rise  = ~sck_p_q & sck_s_q & ~cs_s_q;
    assign sck_fall  = sck_p_q & ~sck_s_q & ~cs_s_q;
    // The eighth command bit is taken live so the decode lands on its edge.
    assign cmd_byte  = {sr_q, mosi_s_q};
    assign stat_byte = {6'b0, wel_q, wip_q};
    assign bcnt_d    = (bcnt_q == 6'd63) ? bcnt_q : bcnt_q + 6'd1;

    always_comb begin
        id_byte = 8'h00;
        case (idx_q)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cs_m_q    <= 1'b1;
            cs_s_q    <= 1'b1;
            cs_p_q    <= 1'b1;
            sck_m_q   <= 1'b0;
            sck_s_q   <= 1'b0;
            sck_p_q   <= 1'b0;
            mosi_m_q  <= 1'b0;
            mosi_s_q  <= 1'b0;
            sr_q      <= '0;
            bcnt_q    <= '0;
            ph_q      <= '0;
            idx_q     <= '0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            wip_q     <= 1'b0;
            wel_q     <= 1'b0;
            se_done_q <= 1'b0;
            se_addr_q <= '0;
            busy_q    <= '0;
        end else begin
            cs_m_q    <= cs_n;
            cs_s_q    <= cs_m_q;
            cs_p_q    <= cs_s_q;
            sck_m_q   <= sck;
            sck_s_q   <= sck_m_q;
            sck_p_q   <= sck_s_q;
            mosi_m_q  <= mosi;
            mosi_s_q  <= mosi_m_q;
            se_done_q <= 1'b0;

            if (wip_q) begin
                if (busy_q == 32'd0) begin
                    wip_q     <= 1'b0;
                    wel_q     <= 1'b0;
                    se_done_q <= 1'b1;
                end else begin
                    busy_q <= busy_q - 32'd1;
                end
            end

            if (cs_rise) begin
                state_q <= IDLE;
                miso_q  <= 1'b0;
                if (wren_q && bcnt_q == 6'd8 && !wip_q)
                    wel_q <= 1'b1;
                if (state_q == ADDR && bcnt_q == 6'd32 && wel_q && !wip_q) begin
                    se_addr_q <= addr_q;
                    wip_q     <= 1'b1;
                    busy_q    <= BUSY_CYC - 32'd1;
                end
            end else if (cs_fall) begin
                state_q <= CMD;
                sr_q    <= '0;
                bcnt_q  <= '0;
                ph_q    <= '0;
                idx_q   <= '0;
                wren_q  <= 1'b0;
                tx_q    <= '0;
                miso_q  <= 1'b0;
            end else if (sck_rise) begin
                sr_q   <= cmd_byte[6:0];
                bcnt_q <= bcnt_d;
                ph_q   <= ph_q + 3'd1;
                unique case (state_q)
                    CMD: begin
                        if (ph_q == 3'd7) begin
                            unique case (1'b1)
                                (cmd_byte == 8'h06): begin
                                    wren_q  <= 1'b1;
                                    state_q <= IGNORE;
                                end
                                (cmd_byte == 8'h05): begin
                                    tx_q    <= stat_byte;
                                    state_q <= STAT;
                                end
                                (cmd_byte == 8'hD8): begin
                                    state_q <= ADDR;
                                end
`ifdef SPI_FLASH_RESP_RDID_EN
                                (cmd_byte == 8'h9F): begin
                                    tx_q    <= JEDEC_ID[23:16];
                                    idx_q   <= 2'd1;
                                    state_q <= ID;
                                end
`endif
                                default: state_q <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: addr_q <= {addr_q[22:0], mosi_s_q};
                    STAT: begin
                        if (ph_q == 3'd7)
                            tx_q <= stat_byte;
                    end
                    ID: begin
                        if (ph_q == 3'd7) begin
                            tx_q <= id_byte;
                            if (idx_q != 2'd3)
                                idx_q <= idx_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (sck_fall) begin
                if (state_q == STAT || state_q == ID) begin
                    miso_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end else begin
                    miso_q <= 1'b0;
                end
            end
        end
    end

    assign miso    = miso_q;
    assign se_done = se_done_q;
    assign se_addr = se_addr_q;
    assign wip     = wip_q;
    assign wel     = wel_q;

endmodule

// File: doc/spi_flash_resp.md
SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

Interface
REQ-001 SHALL provide parameter BUSY_CYC, default 32'd2_500_000; sys_clk cycles WIP stays 1 after an accepted erase.
REQ-002 SHALL provide parameter JEDEC_ID, default 24'hEF4017; the 3-byte ID returned by RDID.
REQ-003 SHALL provide port sys_clk  input  1  system clock (50 MHz); the only clock.
REQ-004 SHALL provide port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port cs_n  input  1  SPI chip select from master, active low.
REQ-006 SHALL provide port sck  input  1  SPI clock, mode 0; sck period >= 8 sys_clk.
REQ-007 SHALL provide port mosi  input  1  SPI data, master to responder, MSB first.
REQ-008 SHALL provide port miso  output  1  SPI data, responder to master, MSB first.
REQ-009 SHALL provide port se_done  output  1  one-cycle pulse when an erase busy period ends.
REQ-010 SHALL provide port se_addr  output  24  address of the last accepted sector erase.
REQ-011 SHALL provide port wip  output  1  write-in-progress status bit.
REQ-012 SHALL provide port wel  output  1  write-enable-latch status bit.

Function
REQ-013 SHALL pass cs_n, sck and mosi through 2-flop synchronizers; all edge detection uses the synchronized signals.
REQ-014 SHALL sample mosi on each synchronized sck rising edge while cs_n is low, shifting into an 8-bit register; a bit counter counts rising edges from cs_n falling.
REQ-015 SHALL use FSM states IDLE, CMD, ADDR, STAT, ID and IGNORE; cs_n falling enters CMD; cs_n rising returns to IDLE from any state.
REQ-016 SHALL decode the command byte on the 8th rising edge: 8'h06 WREN, 8'h05 RDSR -> STAT, 8'hD8 SE -> ADDR, 8'h9F RDID -> ID; any other code -> IGNORE.
REQ-017 SHALL set wel on cs_n rising after exactly 8 bits of WREN while wip=0; otherwise wel is unchanged.
REQ-018 SHALL in ADDR shift 24 address bits MSB first; SE is accepted only on cs_n rising at exactly bit count 32 with wel=1 and wip=0.
REQ-019 SHALL on SE acceptance load se_addr, set wip=1 and load the busy counter with BUSY_CYC-1.
REQ-020 SHALL decrement the busy counter each cycle while wip=1; at zero it clears wip and wel and pulses se_done for one cycle.
REQ-021 SHALL ignore SE with a bit count other than 32, wel=0, or wip=1; WREN with wip=1 is also ignored.
REQ-022 SHALL in STAT shift out {6'b0, wel, wip} on miso repeatedly while cs_n is low, re-latching the status at each byte boundary.
REQ-023 SHALL change miso only on synchronized sck falling edges; the first response bit is driven on the falling edge after the 8th rising edge.
REQ-024 SHALL keep miso propagation at most 3 sys_clk after the physical sck falling edge.
REQ-025 SHALL drive miso 0 whenever cs_n is high and in the CMD, ADDR and IGNORE states.
REQ-026 SHALL treat cs_n rising mid-byte as an abort: partial data is discarded with no state change except when REQ-018 is met.

Reset
REQ-027 SHALL on sys_rst_n low asynchronously set the state to IDLE and clear miso, wip, wel, se_done, se_addr, the shift registers, bit counter, busy counter and synchronizers (cs_n synchronizer to 1).
REQ-028 SHALL abort any transaction or busy period in progress when reset asserts mid-operation; no se_done pulse is generated.

Configuration
REQ-029 SHALL compile RDID support only when macro SPI_FLASH_RESP_RDID_EN is defined; in ID state it shifts out JEDEC_ID MSB first, then 8'h00.
REQ-030 SHALL treat 8'h9F as an unknown command (IGNORE, miso=0) when SPI_FLASH_RESP_RDID_EN is undefined.

Verification
REQ-031 SHALL cover WREN (06) then RDSR (05) -> miso byte 8'h02, wel=1.
REQ-032 SHALL cover WREN, SE D8 01 23 45 with BUSY_CYC=100 -> se_addr=24'h012345, wip=1 for 100 cycles, RDSR returns 8'h03, then a se_done pulse and wip=wel=0.
REQ-033 SHALL cover SE without WREN -> wip stays 0, se_addr unchanged, no se_done.
REQ-034 SHALL cover WREN, then SE with cs_n raised after 20 bits -> ignored, wel stays 1.
REQ-035 SHALL cover, with SPI_FLASH_RESP_RDID_EN defined, 9F -> miso EF 40 17; with it undefined -> miso 0.
REQ-036 SHALL cover sys_rst_n pulsed low during busy -> wip=wel=0 immediately and no se_done.
